fountain_v1_decoder: RTL and testbench

Receive-side counterpart of the fountain encoder. Accepts encoded symbols, each carrying its K-bit coefficient mask, and recovers the K source symbols by iterative peeling with XOR reduction. Degree ≥ 2 symbols are buffered until they can be resolved. Once all source symbols are known, it streams them out in index order and pulses `done`.

---
 rtl/fountain_v1_decoder_if.sv | 28 ++
 rtl/fountain_v1_decoder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_fountain_v1_decoder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fountain_v1_decoder_if.sv
// Symbol handshake bundle for the fountain decoder.
// The "slave" modport is the decoder side and the "master" modport is the source/sink side.
interface fountain_v1_decoder_if #(
    parameter int unsigned K = 8,
    parameter int unsigned W = 8
) ();
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;

    logic          in_valid;
    logic          in_ready;
    logic [K-1:0]  in_mask;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_index;
    logic [W-1:0]  out_data;
    logic          out_last;

    modport slave (
        input  in_valid, in_mask, in_data, out_ready,
        output in_ready, out_valid, out_index, out_data, out_last
    );

    modport master (
        output in_valid, in_mask, in_data, out_ready,
        input  in_ready, out_valid, out_index, out_data, out_last
    );
endinterface

// File: rtl/fountain_v1_decoder.sv
// Peeling fountain decoder: reduces each encoded symbol against the recovered sources,
// buffers unresolved symbols, and streams the K sources out once all are known.
module fountain_v1_decoder #(
    parameter int unsigned K = 8,
    parameter int unsigned W = 8,
    parameter int unsigned M = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    fountain_v1_decoder_if.slave    bus,
    output logic                    done,
    output logic                    overflow,
    output logic [$clog2(K+1)-1:0]  recovered_count
);
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned CW = $clog2(K + 1);
    localparam int unsigned PW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_PEEL   = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [W-1:0]  r_src [K];
    logic [K-1:0]  r_rec;
    logic [M-1:0]  r_bv;
    logic [K-1:0]  r_bm [M];
    logic [W-1:0]  r_bd [M];
    logic [K-1:0]  r_in_mask;
    logic [W-1:0]  r_in_data;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_ptr;
    logic [IW-1:0] r_idx;
    logic          r_changed;
    logic          r_overflow;
    logic          r_done;

    logic [K-1:0]  w_op_mask;
    logic [W-1:0]  w_op_data;
    logic [K-1:0]  w_new_mask;
    logic [W-1:0]  w_new_data;
    logic          w_zero;
    logic          w_one;
    logic [IW-1:0] w_bit;
    logic          w_free_found;
    logic [PW-1:0] w_free_idx;
    logic          w_recover;
    logic [CW-1:0] w_count_next;
    logic          w_in_ready;
    logic          w_hs_in;
    logic          w_hs_out;
    logic          w_ptr_last;
    logic          w_clear;
    logic          w_start_clr;
    logic          w_store;
    logic          w_drop;
    logic          w_free;
    logic          w_wb;
    logic          w_fin;

    // One shared reduction datapath: the latched input in REDUCE, buffer entry r_ptr in PEEL.
    assign w_op_mask  = (r_state == ST_PEEL) ? r_bm[r_ptr] : r_in_mask;
    assign w_op_data  = (r_state == ST_PEEL) ? r_bd[r_ptr] : r_in_data;
    assign w_new_mask = w_op_mask & ~r_rec;

    always_comb begin
        w_new_data = w_op_data;
        for (int unsigned j = 0; j < K; j++) begin
            if (w_op_mask[j] && r_rec[j]) begin
                w_new_data = w_new_data ^ r_src[j];
            end
        end
    end

    assign w_zero = (w_new_mask == '0);
    assign w_one  = !w_zero && ((w_new_mask & (w_new_mask - K'(1))) == '0);

    always_comb begin
        w_bit = '0;
        for (int unsigned j = 0; j < K; j++) begin
            if (w_new_mask[j]) begin
                w_bit = IW'(j);
            end
        end
    end

    // Lowest-index free slot wins: the loop runs downward, so the last hit is the lowest.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = int'(M) - 1; i >= 0; i--) begin
            if (!r_bv[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = PW'(i);
            end
        end
    end

    assign w_recover    = w_one && ((r_state == ST_REDUCE) ||
                                    ((r_state == ST_PEEL) && r_bv[r_ptr]));
    assign w_count_next = r_count + CW'(w_recover);
    assign w_ptr_last   = (r_ptr == PW'(M - 1));

    assign w_in_ready = (r_state == ST_IDLE) && !start && !reset;
    assign w_hs_in    = w_in_ready && bus.in_valid;
    assign w_hs_out   = (r_state == ST_OUT) && bus.out_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_start_clr = 1'b0;
        w_store     = 1'b0;
        w_drop      = 1'b0;
        w_free      = 1'b0;
        w_wb        = 1'b0;
        w_fin       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_start_clr = 1'b1;
                end else if (w_hs_in) begin
                    w_state_nxt = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (w_zero) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_one) begin
                    w_state_nxt = (w_count_next == CW'(K)) ? ST_OUT : ST_PEEL;
                end else begin
                    w_store     = w_free_found;
                    w_drop      = !w_free_found;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PEEL: begin
                if (r_bv[r_ptr]) begin
                    w_free = w_zero || w_one;
                    w_wb   = !w_zero && !w_one;
                end
                if (w_ptr_last) begin
                    if (w_count_next == CW'(K)) begin
                        w_state_nxt = ST_OUT;
                    end else if (r_changed || w_recover) begin
                        w_state_nxt = ST_PEEL;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_OUT: begin
                if (w_hs_out && (r_idx == IW'(K - 1))) begin
                    w_fin       = 1'b1;
                    w_clear     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Source store, buffer, counters and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned j = 0; j < K; j++) begin
                r_src[j] <= '0;
            end
            for (int unsigned i = 0; i < M; i++) begin
                r_bm[i] <= '0;
                r_bd[i] <= '0;
            end
            r_rec      <= '0;
            r_bv       <= '0;
            r_in_mask  <= '0;
            r_in_data  <= '0;
            r_count    <= '0;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_changed  <= 1'b0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_hs_in) begin
                r_in_mask <= bus.in_mask;
                r_in_data <= bus.in_data;
            end
            if (w_clear) begin
                r_rec   <= '0;
                r_bv    <= '0;
                r_count <= '0;
            end
            if (w_start_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_recover) begin
                r_src[w_bit] <= w_new_data;
                r_rec[w_bit] <= 1'b1;
                r_count      <= w_count_next;
            end
            if (w_store) begin
                r_bv[w_free_idx] <= 1'b1;
                r_bm[w_free_idx] <= w_new_mask;
                r_bd[w_free_idx] <= w_new_data;
            end
            if (w_free) begin
                r_bv[r_ptr] <= 1'b0;
            end
            if (w_wb) begin
                r_bm[r_ptr] <= w_new_mask;
                r_bd[r_ptr] <= w_new_data;
            end
            // A pass restarts at entry 0 with a clean changed flag.
            if (r_state == ST_REDUCE) begin
                r_ptr     <= '0;
                r_changed <= 1'b0;
            end else if (r_state == ST_PEEL) begin
                if (w_ptr_last) begin
                    r_ptr     <= '0;
                    r_changed <= 1'b0;
                end else begin
                    r_ptr <= r_ptr + PW'(1);
                    if (w_recover) begin
                        r_changed <= 1'b1;
                    end
                end
            end
            if (w_fin) begin
                r_idx <= '0;
            end else if (w_hs_out) begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = (r_state == ST_OUT);
    assign bus.out_index   = r_idx;
    assign bus.out_data    = r_src[r_idx];
    assign bus.out_last    = (r_state == ST_OUT) && (r_idx == IW'(K - 1));
    assign done            = r_done;
    assign overflow        = r_overflow;
    assign recovered_count = r_count;

endmodule

// File: tb/tb_fountain_v1_decoder.sv
// Bench for fountain_v1_decoder at K=4, W=8, M=4: table of symbols with expected
// count/flags/latency, plus a scoreboard of expected output beats.
module tb_fountain_v1_decoder;
    localparam int unsigned K = 4;
    localparam int unsigned W = 8;
    localparam int unsigned M = 4;

    typedef struct {
        logic [3:0] mask;
        logic [7:0] data;
        int         cnt;
        int         ovf;
        int         lat;
        bit         drain;
        bit         bp;
    } vec_t;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
        logic       last;
    } out_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic       overflow;
    logic [2:0] recovered_count;

    int n_checks = 0;
    int n_errors = 0;

    vec_t tbl [20];
    out_t sb [$];
    logic [7:0] src_val [4];

    fountain_v1_decoder_if #(.K(K), .W(W)) bus ();

    fountain_v1_decoder #(.K(K), .W(W), .M(M)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .bus             (bus),
        .done            (done),
        .overflow        (overflow),
        .recovered_count (recovered_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_out_index"}, int'(bus.out_index), 0);
        chk({tag, "_out_data"}, int'(bus.out_data), 0);
        chk({tag, "_out_last"}, int'(bus.out_last), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_count"}, int'(recovered_count), 0);
    endtask

    // Expected beats are queued up front and popped as the DUT presents them.
    task automatic drain(input bit bp);
        out_t e;
        int   w;
        for (int i = 0; i < 4; i++) begin
            e.idx  = 2'(i);
            e.data = src_val[i];
            e.last = (i == 3);
            sb.push_back(e);
        end
        bus.out_ready = 1'b1;
        while (sb.size() > 0) begin
            w = 0;
            while (!bus.out_valid && w < 50) begin
                @(negedge clk);
                w++;
            end
            chk("out_valid_wait", int'(bus.out_valid), 1);
            if (!bus.out_valid) begin
                sb.delete();
                break;
            end
            e = sb.pop_front();
            chk("done_early", int'(done), 0);
            if (bp && e.idx == 2'd2) begin
                bus.out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk("bp_valid", int'(bus.out_valid), 1);
                    chk("bp_index", int'(bus.out_index), int'(e.idx));
                    chk("bp_data", int'(bus.out_data), int'(e.data));
                    chk("bp_done", int'(done), 0);
                end
                bus.out_ready = 1'b1;
            end
            chk("out_index", int'(bus.out_index), int'(e.idx));
            chk("out_data", int'(bus.out_data), int'(e.data));
            chk("out_last", int'(bus.out_last), int'(e.last));
            @(negedge clk);
        end
        chk("done_pulse", int'(done), 1);
        chk("out_valid_after", int'(bus.out_valid), 0);
        chk("count_after_out", int'(recovered_count), 0);
        @(negedge clk);
        chk("done_clear", int'(done), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int w;
        int lat;
        bus.in_mask  = v.mask;
        bus.in_data  = v.data;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_wait", int'(bus.in_ready), 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.in_ready && !bus.out_valid && lat < 200);
        chk("latency", lat, v.lat);
        chk("count", int'(recovered_count), v.cnt);
        chk("overflow", int'(overflow), v.ovf);
        if (v.drain) begin
            chk("enter_out", int'(bus.out_valid), 1);
            drain(v.bp);
        end
    endtask

    initial begin
        src_val[0] = 8'h11; src_val[1] = 8'h22; src_val[2] = 8'h44; src_val[3] = 8'h88;
        // systematic
        tbl[0]  = '{4'h1, 8'h11, 1, 0, 6, 1'b0, 1'b0};
        tbl[1]  = '{4'h2, 8'h22, 2, 0, 6, 1'b0, 1'b0};
        tbl[2]  = '{4'h4, 8'h44, 3, 0, 6, 1'b0, 1'b0};
        tbl[3]  = '{4'h8, 8'h88, 4, 0, 2, 1'b1, 1'b0};
        // peel chain
        tbl[4]  = '{4'h3, 8'h33, 0, 0, 2, 1'b0, 1'b0};
        tbl[5]  = '{4'h6, 8'h66, 0, 0, 2, 1'b0, 1'b0};
        tbl[6]  = '{4'hC, 8'hCC, 0, 0, 2, 1'b0, 1'b0};
        tbl[7]  = '{4'h1, 8'h11, 4, 0, 6, 1'b1, 1'b0};
        // redundant
        tbl[8]  = '{4'h1, 8'h11, 1, 0, 6, 1'b0, 1'b0};
        tbl[9]  = '{4'h1, 8'h11, 1, 0, 2, 1'b0, 1'b0};
        tbl[10] = '{4'h0, 8'h00, 1, 0, 2, 1'b0, 1'b0};
        tbl[11] = '{4'h2, 8'h22, 2, 0, 6, 1'b0, 1'b0};
        tbl[12] = '{4'h4, 8'h44, 3, 0, 6, 1'b0, 1'b0};
        tbl[13] = '{4'h8, 8'h88, 4, 0, 2, 1'b1, 1'b0};
        // overflow, drained with backpressure at index 2
        tbl[14] = '{4'h3, 8'h33, 0, 0, 2, 1'b0, 1'b0};
        tbl[15] = '{4'h6, 8'h66, 0, 0, 2, 1'b0, 1'b0};
        tbl[16] = '{4'hC, 8'hCC, 0, 0, 2, 1'b0, 1'b0};
        tbl[17] = '{4'h9, 8'h99, 0, 0, 2, 1'b0, 1'b0};
        tbl[18] = '{4'h5, 8'h55, 0, 1, 2, 1'b0, 1'b0};
        tbl[19] = '{4'h1, 8'h11, 4, 1, 6, 1'b1, 1'b1};

        reset         = 1'b1;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mask   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_in_ready", int'(bus.in_ready), 1);
        chk("rel_count", int'(recovered_count), 0);

        for (int i = 0; i < 20; i++) begin
            run_vec(tbl[i]);
        end

        chk("ovf_held", int'(overflow), 1);
        @(negedge clk);
        start = 1'b1;
        #1 chk("start_blocks_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("start_clears_ovf", int'(overflow), 0);
        chk("start_ready", int'(bus.in_ready), 1);

        // Reset in the middle of a peel pass.
        for (int i = 4; i < 7; i++) begin
            run_vec(tbl[i]);
        end
        bus.in_mask  = 4'h1;
        bus.in_data  = 8'h11;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("peel_mid_count", int'(recovered_count), 2);
        reset = 1'b1;
        #1;
        chk_all_zero("midpeel_reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_ready", int'(bus.in_ready), 1);
        chk("post_reset_count", int'(recovered_count), 0);
        for (int i = 0; i < 4; i++) begin
            run_vec(tbl[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
